// File: rtl/uart_pkg.sv
// Shared UART definitions for the receiver and the companion byte transmitter.
//
// Contents:
//   uart_state_t : frame-level state encoding (IDLE, START, DATA, STOP)
//   DATA_BITS    : payload bits per frame (8N1 framing)
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } uart_state_t;

    localparam int DATA_BITS = 8;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for a single asynchronous input.
//
// Parameters:
//   RESET_VAL : value both flops take during reset. An idle UART line is high,
//               so the receiver uses 1 to avoid a fake start edge after reset.
//
// Ports:
//   clk     : system clock
//   rst     : synchronous active-high reset
//   i_async : asynchronous input
//   o_sync  : input re-timed into the clk domain, two cycles of latency
module uart_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    // The first flop may go metastable; only the second flop is used.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a fixed oversampling ratio and mid-bit sampling.
//
// Parameters:
//   CLKS_PER_BIT : clk cycles per serial bit (4..65535)
//
// Ports:
//   clk       : system clock
//   rst       : synchronous active-high reset; aborts any frame in progress
//   rxd       : serial line, asynchronous to clk, idle high
//   data_i    : last correctly framed byte, held until the next good byte
//   rx_done   : one-cycle pulse, data_i is new in the same cycle
//   frame_err : one-cycle pulse, stop bit was sampled low
//   busy      : high whenever the receiver is not idle
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] data_i,
    output logic                 rx_done,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       IDX_LAST  = 3'(DATA_BITS - 1);

    uart_state_t          r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [2:0]           r_idx;
    logic [DATA_BITS-1:0] r_sh;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_done;
    logic                 r_err;

    uart_state_t          w_nextState;
    logic [CNT_W-1:0]     w_nextCnt;
    logic [2:0]           w_nextIdx;
    logic [DATA_BITS-1:0] w_nextSh;
    logic [DATA_BITS-1:0] w_nextData;
    logic                 w_nextDone;
    logic                 w_nextErr;
    logic                 w_rxdSync;

    uart_sync #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (rxd),
        .o_sync  (w_rxdSync)
    );

    // State, counters, shift register and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_sh    <= '0;
            r_data  <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_cnt   <= w_nextCnt;
            r_idx   <= w_nextIdx;
            r_sh    <= w_nextSh;
            r_data  <= w_nextData;
            r_done  <= w_nextDone;
            r_err   <= w_nextErr;
        end
    end

    // Next-state logic. The start bit is checked at its midpoint; from there
    // every full bit period lands in the middle of the next bit. The stop bit
    // is also judged at its midpoint and the FSM returns to IDLE right away,
    // so a start edge that follows immediately is still seen on time.
    always_comb begin
        w_nextState = r_state;
        w_nextCnt   = r_cnt;
        w_nextIdx   = r_idx;
        w_nextSh    = r_sh;
        w_nextData  = r_data;
        w_nextDone  = 1'b0;
        w_nextErr   = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (!w_rxdSync) begin
                    w_nextState = START;
                    w_nextCnt   = '0;
                end
            end

            START: begin
                w_nextCnt = r_cnt + 1'b1;
                if (r_cnt == HALF_LAST) begin
                    w_nextCnt = '0;
                    if (!w_rxdSync) begin
                        w_nextState = DATA;
                        w_nextIdx   = '0;
                    end else begin
                        // Line went back high before mid-start: treat as noise.
                        w_nextState = IDLE;
                    end
                end
            end

            DATA: begin
                w_nextCnt = r_cnt + 1'b1;
                if (r_cnt == BIT_LAST) begin
                    w_nextCnt = '0;
                    w_nextSh  = {w_rxdSync, r_sh[DATA_BITS-1:1]};
                    w_nextIdx = r_idx + 3'd1;
                    if (r_idx == IDX_LAST) begin
                        w_nextState = STOP;
                    end
                end
            end

            STOP: begin
                w_nextCnt = r_cnt + 1'b1;
                if (r_cnt == BIT_LAST) begin
                    w_nextCnt   = '0;
                    w_nextState = IDLE;
                    if (w_rxdSync) begin
                        w_nextData = r_sh;
                        w_nextDone = 1'b1;
                    end else begin
                        w_nextErr = 1'b1;
                    end
                end
            end

            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    assign data_i    = r_data;
    assign rx_done   = r_done;
    assign frame_err = r_err;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx. Two instances are exercised: one at the
// default 16 clocks per bit and one at 4 clocks per bit. A background monitor
// records every rx_done / frame_err pulse with its cycle number, and each
// scenario task compares those records against hand-computed values.
module tb_uart_rx;

    logic       clk;
    logic       rst;
    logic       rxd16;
    logic       rxd4;
    logic [7:0] data16;
    logic [7:0] data4;
    logic       done16;
    logic       done4;
    logic       err16;
    logic       err4;
    logic       busy16;
    logic       busy4;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int         doneCyc16[$];
    logic [7:0] doneData16[$];
    int         errCyc16[$];
    int         doneCyc4[$];
    logic [7:0] doneData4[$];
    int         errCyc4[$];
    int         busyCnt16 = 0;
    int         overlapCnt = 0;

    uart_rx #(.CLKS_PER_BIT(16)) dut16 (
        .clk       (clk),
        .rst       (rst),
        .rxd       (rxd16),
        .data_i    (data16),
        .rx_done   (done16),
        .frame_err (err16),
        .busy      (busy16)
    );

    uart_rx #(.CLKS_PER_BIT(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .rxd       (rxd4),
        .data_i    (data4),
        .rx_done   (done4),
        .frame_err (err4),
        .busy      (busy4)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle number: after posedge N, cyc == N.
    always @(posedge clk) begin
        cyc <= cyc + 1;
    end

    // Pulse recorder, sampled away from the active edge.
    always @(negedge clk) begin
        if (done16) begin
            doneCyc16.push_back(cyc);
            doneData16.push_back(data16);
        end
        if (err16) errCyc16.push_back(cyc);
        if (done4) begin
            doneCyc4.push_back(cyc);
            doneData4.push_back(data4);
        end
        if (err4) errCyc4.push_back(cyc);
        if (busy16) busyCnt16 = busyCnt16 + 1;
        if ((done16 && err16) || (done4 && err4)) overlapCnt = overlapCnt + 1;
    end

    task automatic setLine(input bit sel4, input logic v);
        if (sel4) rxd4 = v;
        else      rxd16 = v;
    endtask

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    // Drives one frame. Must be called 1 ns after a posedge; returns at the
    // same phase so frames can be chained with no gap. ck is the edge that
    // first samples the start bit low. The line is left at the stop value.
    task automatic sendFrame(input bit sel4, input logic [7:0] b,
                             input logic stopBit, output int ck);
        int cpb;
        cpb = sel4 ? 4 : 16;
        setLine(sel4, 1'b0);
        ck = cyc + 1;
        repeat (cpb) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            setLine(sel4, b[i]);
            repeat (cpb) @(posedge clk);
            #1;
        end
        setLine(sel4, stopBit);
        repeat (cpb) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks += 8;
        if (data16 !== 8'h00) begin failures++; $display("[TB] FAIL reset_data16: got %h expected 00", data16); end
        if (done16 !== 1'b0)  begin failures++; $display("[TB] FAIL reset_done16: got %b expected 0", done16); end
        if (err16 !== 1'b0)   begin failures++; $display("[TB] FAIL reset_err16: got %b expected 0", err16); end
        if (busy16 !== 1'b0)  begin failures++; $display("[TB] FAIL reset_busy16: got %b expected 0", busy16); end
        if (data4 !== 8'h00)  begin failures++; $display("[TB] FAIL reset_data4: got %h expected 00", data4); end
        if (done4 !== 1'b0)   begin failures++; $display("[TB] FAIL reset_done4: got %b expected 0", done4); end
        if (err4 !== 1'b0)    begin failures++; $display("[TB] FAIL reset_err4: got %b expected 0", err4); end
        if (busy4 !== 1'b0)   begin failures++; $display("[TB] FAIL reset_busy4: got %b expected 0", busy4); end
        align();
        rst = 1'b0;
        repeat (5) @(posedge clk);
    endtask

    task automatic test_single_byte();
        int n0, e0, ck;
        n0 = doneCyc16.size();
        e0 = errCyc16.size();
        align();
        sendFrame(1'b0, 8'h55, 1'b1, ck);
        repeat (10) @(posedge clk);
        @(negedge clk);
        checks += 5;
        if (doneCyc16.size() - n0 != 1) begin
            failures++; $display("[TB] FAIL single_count: got %0d pulses expected 1", doneCyc16.size() - n0);
        end else begin
            if (doneCyc16[n0] - ck != 154) begin failures++; $display("[TB] FAIL single_latency: got %0d expected 154", doneCyc16[n0] - ck); end
            if (doneData16[n0] !== 8'h55) begin failures++; $display("[TB] FAIL single_pulse_data: got %h expected 55", doneData16[n0]); end
        end
        if (errCyc16.size() != e0) begin failures++; $display("[TB] FAIL single_err: got %0d errors expected 0", errCyc16.size() - e0); end
        if (busy16 !== 1'b0)       begin failures++; $display("[TB] FAIL single_busy: got %b expected 0", busy16); end
    endtask

    task automatic test_back_to_back();
        int n0, ck1, ck2;
        n0 = doneCyc16.size();
        align();
        sendFrame(1'b0, 8'hA3, 1'b1, ck1);
        sendFrame(1'b0, 8'h3C, 1'b1, ck2);
        repeat (10) @(posedge clk);
        @(negedge clk);
        checks += 5;
        if (doneCyc16.size() - n0 != 2) begin
            failures++; $display("[TB] FAIL b2b_count: got %0d pulses expected 2", doneCyc16.size() - n0);
        end else begin
            if (doneData16[n0] !== 8'hA3)   begin failures++; $display("[TB] FAIL b2b_first: got %h expected a3", doneData16[n0]); end
            if (doneData16[n0+1] !== 8'h3C) begin failures++; $display("[TB] FAIL b2b_second: got %h expected 3c", doneData16[n0+1]); end
            if (doneCyc16[n0+1] - doneCyc16[n0] != 160) begin
                failures++; $display("[TB] FAIL b2b_spacing: got %0d expected 160", doneCyc16[n0+1] - doneCyc16[n0]);
            end
        end
        if (data16 !== 8'h3C) begin failures++; $display("[TB] FAIL b2b_hold: got %h expected 3c", data16); end
    endtask

    task automatic test_framing_error();
        int n0, e0, ck;
        n0 = doneCyc16.size();
        e0 = errCyc16.size();
        align();
        sendFrame(1'b0, 8'h81, 1'b0, ck);
        setLine(1'b0, 1'b1);
        repeat (30) @(posedge clk);
        @(negedge clk);
        checks += 5;
        if (errCyc16.size() - e0 != 1) begin
            failures++; $display("[TB] FAIL ferr_count: got %0d errors expected 1", errCyc16.size() - e0);
        end else if (errCyc16[e0] - ck != 154) begin
            failures++; $display("[TB] FAIL ferr_latency: got %0d expected 154", errCyc16[e0] - ck);
        end
        if (doneCyc16.size() != n0) begin failures++; $display("[TB] FAIL ferr_done: got %0d pulses expected 0", doneCyc16.size() - n0); end
        if (data16 !== 8'h3C)       begin failures++; $display("[TB] FAIL ferr_data: got %h expected 3c", data16); end
        if (busy16 !== 1'b0)        begin failures++; $display("[TB] FAIL ferr_busy: got %b expected 0", busy16); end
    endtask

    task automatic test_glitch();
        int n0, e0, b0;
        n0 = doneCyc16.size();
        e0 = errCyc16.size();
        b0 = busyCnt16;
        align();
        setLine(1'b0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        setLine(1'b0, 1'b1);
        repeat (30) @(posedge clk);
        @(negedge clk);
        checks += 4;
        if (busyCnt16 - b0 != 8)    begin failures++; $display("[TB] FAIL glitch_busy_cycles: got %0d expected 8", busyCnt16 - b0); end
        if (doneCyc16.size() != n0) begin failures++; $display("[TB] FAIL glitch_done: got %0d pulses expected 0", doneCyc16.size() - n0); end
        if (errCyc16.size() != e0)  begin failures++; $display("[TB] FAIL glitch_err: got %0d errors expected 0", errCyc16.size() - e0); end
        if (data16 !== 8'h3C)       begin failures++; $display("[TB] FAIL glitch_data: got %h expected 3c", data16); end
    endtask

    task automatic test_reset_mid_frame();
        int n0, e0, ck;
        n0 = doneCyc16.size();
        e0 = errCyc16.size();
        align();
        fork
            sendFrame(1'b0, 8'hFF, 1'b1, ck);
            begin
                // Reset lands 84 edges after the start bit is first sampled,
                // in the middle of data bit 4.
                repeat (84) @(posedge clk);
                #1;
                rst = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
                @(negedge clk);
                checks += 2;
                if (data16 !== 8'h00) begin failures++; $display("[TB] FAIL rstmid_data: got %h expected 00", data16); end
                if (busy16 !== 1'b0)  begin failures++; $display("[TB] FAIL rstmid_busy: got %b expected 0", busy16); end
            end
        join
        repeat (20) @(posedge clk);
        @(negedge clk);
        checks += 2;
        if (doneCyc16.size() != n0 || errCyc16.size() != e0) begin
            failures++; $display("[TB] FAIL rstmid_pulses: got done=%0d err=%0d expected 0 0",
                                 doneCyc16.size() - n0, errCyc16.size() - e0);
        end
        if (data16 !== 8'h00) begin failures++; $display("[TB] FAIL rstmid_final_data: got %h expected 00", data16); end
    endtask

    task automatic test_after_reset();
        int n0, ck;
        n0 = doneCyc16.size();
        align();
        sendFrame(1'b0, 8'h12, 1'b1, ck);
        repeat (10) @(posedge clk);
        @(negedge clk);
        checks += 3;
        if (doneCyc16.size() - n0 != 1) begin
            failures++; $display("[TB] FAIL after_count: got %0d pulses expected 1", doneCyc16.size() - n0);
        end else if (doneCyc16[n0] - ck != 154) begin
            failures++; $display("[TB] FAIL after_latency: got %0d expected 154", doneCyc16[n0] - ck);
        end
        if (data16 !== 8'h12) begin failures++; $display("[TB] FAIL after_data: got %h expected 12", data16); end
        if (busy16 !== 1'b0)  begin failures++; $display("[TB] FAIL after_busy: got %b expected 0", busy16); end
    endtask

    task automatic test_cpb4();
        int n0, e0, ck1, ck2;
        n0 = doneCyc4.size();
        e0 = errCyc4.size();
        align();
        sendFrame(1'b1, 8'hC5, 1'b1, ck1);
        sendFrame(1'b1, 8'h00, 1'b1, ck2);
        repeat (20) @(posedge clk);
        @(negedge clk);
        checks += 5;
        if (doneCyc4.size() - n0 != 2) begin
            failures++; $display("[TB] FAIL cpb4_count: got %0d pulses expected 2", doneCyc4.size() - n0);
        end else begin
            if (doneData4[n0] !== 8'hC5)   begin failures++; $display("[TB] FAIL cpb4_first: got %h expected c5", doneData4[n0]); end
            if (doneData4[n0+1] !== 8'h00) begin failures++; $display("[TB] FAIL cpb4_zero: got %h expected 00", doneData4[n0+1]); end
            if (doneCyc4[n0+1] - ck2 != 40) begin failures++; $display("[TB] FAIL cpb4_latency: got %0d expected 40", doneCyc4[n0+1] - ck2); end
        end
        if (errCyc4.size() != e0) begin failures++; $display("[TB] FAIL cpb4_err: got %0d errors expected 0", errCyc4.size() - e0); end
    endtask

    task automatic test_exclusive();
        checks++;
        if (overlapCnt != 0) begin failures++; $display("[TB] FAIL done_err_overlap: got %0d cycles expected 0", overlapCnt); end
    endtask

    initial begin
        rst   = 1'b1;
        rxd16 = 1'b1;
        rxd4  = 1'b1;
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_framing_error();
        test_glitch();
        test_reset_mid_frame();
        test_after_reset();
        test_cpb4();
        test_exclusive();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Asynchronous serial receiver: 8N1 frame (1 start bit low, 8 data bits LSB first, 1 stop bit high), idle line high.
- Companion to the team's byte transmitter. Sits between the external RX pin and byte-wide consumer logic.
- Oversamples with a fixed clocks-per-bit count, samples at mid-bit, and reports each byte with a one-cycle done pulse or a framing-error pulse.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per serial bit; legal range 4..65535. HALF = CLKS_PER_BIT/2 (integer division).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- rxd  input  1  serial line, asynchronous to clk.
- data_i  output  8  last correctly framed byte; holds until the next good byte.
- rx_done  output  1  one-cycle pulse; data_i is valid and new in the same cycle.
- frame_err  output  1  one-cycle pulse; stop bit sampled low.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE; synchronizer flops=1; counters=0.
  - data_i=8'h00, rx_done=0, frame_err=0, busy=0.
- Reset mid-frame aborts the frame. No pulse is generated and data_i returns to 0.
- rxd passes through a 2-flop synchronizer; the result is rxd_s. All decisions use rxd_s only.
- Bit counter cnt is width $clog2(CLKS_PER_BIT). Bit index idx is 3 bits. Shift register sh is 8 bits.
- IDLE:
  - If rxd_s==0: go to START, cnt=0.
  - Otherwise stay.
- START:
  - cnt increments each cycle.
  - At cnt==HALF-1, sample rxd_s:
    - 0: go to DATA, cnt=0, idx=0.
    - 1 (glitch/false start): go to IDLE with no pulse.
- DATA:
  - cnt increments each cycle.
  - At cnt==CLKS_PER_BIT-1: sh <= {rxd_s, sh[7:1]}, cnt=0, idx++.
  - When the sample is taken with idx==7, go to STOP.
- STOP:
  - At cnt==CLKS_PER_BIT-1, sample rxd_s, then go to IDLE.
  - rxd_s==1: data_i<=sh and rx_done=1 for exactly one cycle.
  - rxd_s==0: frame_err=1 for one cycle; data_i unchanged.
  - Leaving at mid-stop-bit lets a back-to-back start edge be caught with no gap.
- Latency: with rxd first sampled low at clk edge k, rx_done/frame_err are high in the cycle after edge k+2+HALF+9*CLKS_PER_BIT. For the default 16, that edge is k+154.
- rx_done and frame_err are never high together.
- No input handshake or backpressure. The consumer must take data_i on rx_done; an unread byte is overwritten by the next good byte.
- Break condition (line held low): a frame_err is followed by a new START at IDLE. A repeated frame_err every ~9.5 bit times is the required behaviour.
- Mid-bit sampling tolerates clock mismatch up to roughly ±4% over the frame. No majority vote.

Decomposition:
- uart_pkg:
  - state encodings IDLE=2'b00, START=2'b01, DATA=2'b10, STOP=2'b11.
  - DATA_BITS=8.
  - shared with the transmitter.
- Sub-module uart_sync: 2-flop synchronizer with parameterized reset value (1 here), reusable for other async inputs.
- FSM, counters and shift register stay in uart_rx.

Test Plan:
- Idle then byte 0x55 at CLKS_PER_BIT=16, 16 clks per bit, stop high -> one rx_done pulse 154 cycles after the first low sample edge, data_i=0x55, frame_err=0, busy low afterwards.
- Byte 0xA3 followed immediately by byte 0x3C with no idle gap -> two rx_done pulses 160 cycles apart, data_i=0xA3 then 0x3C.
- Byte 0x81 with stop bit driven low -> frame_err pulse at the stop sample, rx_done stays 0, data_i keeps its previous value. Line then held high -> return to IDLE, busy=0.
- rxd low glitch of 5 cycles (< HALF=8) -> START aborts at cnt==7, no pulse, busy high for exactly 8 cycles, data_i unchanged.
- rst asserted for 1 cycle during DATA bit 4 of byte 0xFF, rxd then idle high -> data_i=0x00, busy=0, no rx_done. A following byte 0x12 is received correctly.
- CLKS_PER_BIT=4, byte 0x00 -> rx_done with data_i=0x00 at latency 2+2+36=40 cycles.
